// File: rtl/neokeon_pkg.sv
// Shared encodings and round-constant arithmetic for the Neokeon-128 round controller.
package neokeon_pkg;

    localparam int          NEOKEON_NR = 16;
    localparam logic [7:0]  RCON_FIRST = 8'h80;
    localparam logic [7:0]  RCON_LAST  = 8'hD4;
    localparam logic [8:0]  RC_POLY    = 9'h11B;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_KEYPREP = 3'd2,
        ST_ROUND   = 3'd3,
        ST_FINAL   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Multiply by x in GF(2^8) modulo RC_POLY.
    function automatic logic [7:0] rcDouble(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? RC_POLY[7:0] : 8'h00);
    endfunction

    // Inverse of rcDouble: divide by x, folding the polynomial in when x is odd.
    function automatic logic [7:0] rcHalve(input logic [7:0] x);
        logic [8:0] t;
        t = x[0] ? ({1'b0, x} ^ RC_POLY) : {1'b0, x};
        return t[8:1];
    endfunction

endpackage

// File: rtl/neokeon_rc_lfsr.sv
// Round-constant register: reloads on request, otherwise doubles (encrypt) or halves (decrypt) per step.
// Latency: new value one cycle after load/step. No backpressure; load has priority over step.
module neokeon_rc_lfsr
    import neokeon_pkg::*;
#(
    parameter logic [7:0] ENC_INIT = RCON_FIRST,
    parameter logic [7:0] DEC_INIT = RCON_LAST
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       load,
    input  logic       loadDec,
    input  logic       step,
    input  logic       dir,
    output logic [7:0] rc
);

    always_ff @(posedge clk) begin
        if (!rstN) begin
            rc <= ENC_INIT;
        end else if (load) begin
            rc <= loadDec ? DEC_INIT : ENC_INIT;
        end else if (step) begin
            rc <= dir ? rcHalve(rc) : rcDouble(rc);
        end
    end

endmodule

// File: rtl/neokeon_round_sequencer.sv
// Sequences one Neokeon encrypt/decrypt job: load, key-prep (decrypt), NR rounds, final Theta, done pulse.
// Latency: done in the NR+3 (enc) / NR+4 (dec) cycle after accept. Busy jobs ignore inStart; inAbort cancels.
module neokeon_round_sequencer
    import neokeon_pkg::*;
#(
    parameter int         NR          = NEOKEON_NR,
    parameter logic [7:0] RC_ENC_INIT = RCON_FIRST,
    parameter logic [7:0] RC_DEC_INIT = RCON_LAST
) (
    input  logic       inClk,
    input  logic       inRstN,
    input  logic       inStart,
    input  logic       inDecrypt,
    input  logic       inAbort,
    output logic       outReady,
    output logic       outLoad,
    output logic       outKeyPrep,
    output logic       outRoundEn,
    output logic       outFinal,
    output logic       outRcPre,
    output logic [7:0] outRC,
    output logic [4:0] outRound,
    output logic       outDone
);

    state_t     state;
    state_t     nxtState;
    logic       mode;
    logic       accept;
    logic       abortJob;
    logic [7:0] rcReg;

    assign accept   = (state == ST_IDLE) && inStart;
    assign abortJob = (state != ST_IDLE) && inAbort;

    always_comb begin
        nxtState = state;
        unique case (state)
            ST_IDLE:    if (inStart) nxtState = ST_LOAD;
            ST_LOAD:    nxtState = mode ? ST_KEYPREP : ST_ROUND;
            ST_KEYPREP: nxtState = ST_ROUND;
            ST_ROUND:   if (outRound == 5'(NR - 1)) nxtState = ST_FINAL;
            ST_FINAL:   nxtState = ST_DONE;
            ST_DONE:    nxtState = ST_IDLE;
            default:    nxtState = ST_IDLE;
        endcase
        if (abortJob) nxtState = ST_IDLE;
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge inClk) begin
        if (!inRstN) begin
            state      <= ST_IDLE;
            mode       <= 1'b0;
            outReady   <= 1'b1;
            outLoad    <= 1'b0;
            outKeyPrep <= 1'b0;
            outRoundEn <= 1'b0;
            outFinal   <= 1'b0;
            outRcPre   <= 1'b0;
            outRound   <= '0;
            outDone    <= 1'b0;
        end else begin
            state      <= nxtState;
            if (accept) mode <= inDecrypt;
            outReady   <= (nxtState == ST_IDLE);
            outLoad    <= (nxtState == ST_LOAD);
            outKeyPrep <= (nxtState == ST_KEYPREP);
            outRoundEn <= (nxtState == ST_ROUND);
            outFinal   <= (nxtState == ST_FINAL);
            outRcPre   <= ((nxtState == ST_ROUND) || (nxtState == ST_FINAL)) && !mode;
            outRound   <= ((state == ST_ROUND) && (nxtState == ST_ROUND)) ? outRound + 5'd1 : 5'd0;
            outDone    <= (nxtState == ST_DONE);
        end
    end

    neokeon_rc_lfsr #(
        .ENC_INIT (RC_ENC_INIT),
        .DEC_INIT (RC_DEC_INIT)
    ) uRcLfsr (
        .clk     (inClk),
        .rstN    (inRstN),
        .load    (accept || abortJob),
        .loadDec (accept && inDecrypt),
        .step    (state == ST_ROUND),
        .dir     (mode),
        .rc      (rcReg)
    );

    assign outRC = (outRoundEn || outFinal) ? rcReg : 8'h00;

endmodule

// File: tb/tb_neokeon_round_sequencer.sv
// Self-checking bench: per-cycle output traces from a behavioural job model, directed and random jobs.
module tb_neokeon_round_sequencer;

    typedef logic [19:0] vec_t;

    logic       clk = 1'b0;
    logic       inRstN, inStart, inDecrypt, inAbort;
    logic       outReady, outLoad, outKeyPrep, outRoundEn, outFinal, outRcPre, outDone;
    logic [7:0] outRC;
    logic [4:0] outRound;
    vec_t       obs;
    vec_t       expQ[$];
    int         total = 0;
    int         bad = 0;
    int         jobNo = 0;

    always #5 clk = ~clk;

    neokeon_round_sequencer dut (
        .inClk      (clk),
        .inRstN     (inRstN),
        .inStart    (inStart),
        .inDecrypt  (inDecrypt),
        .inAbort    (inAbort),
        .outReady   (outReady),
        .outLoad    (outLoad),
        .outKeyPrep (outKeyPrep),
        .outRoundEn (outRoundEn),
        .outFinal   (outFinal),
        .outRcPre   (outRcPre),
        .outRC      (outRC),
        .outRound   (outRound),
        .outDone    (outDone)
    );

    assign obs = {outReady, outLoad, outKeyPrep, outRoundEn, outFinal, outRcPre, outRC, outRound, outDone};

    function automatic vec_t mk(input logic r, input logic l, input logic k, input logic e,
                                input logic f, input logic p, input logic [7:0] rc,
                                input logic [4:0] rn, input logic d);
        return {r, l, k, e, f, p, rc, rn, d};
    endfunction

    localparam vec_t IDLE_V = 20'h80000;

    task automatic chk(input string tag, input vec_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected outputs for every cycle after the accept edge, straight from the job description.
    task automatic buildJob(input bit dec);
        int rc;
        expQ.delete();
        rc = dec ? 'hD4 : 'h80;
        expQ.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 5'd0, 0));
        if (dec) expQ.push_back(mk(0, 0, 1, 0, 0, 0, 8'h00, 5'd0, 0));
        for (int r = 0; r < 16; r++) begin
            expQ.push_back(mk(0, 0, 0, 1, 0, !dec, rc[7:0], r[4:0], 0));
            if (!dec) begin
                rc = rc * 2;
                if (rc > 255) rc = rc ^ 'h11B;
            end else if (rc % 2 == 1) begin
                rc = (rc ^ 'h11B) / 2;
            end else begin
                rc = rc / 2;
            end
        end
        expQ.push_back(mk(0, 0, 0, 0, 1, !dec, rc[7:0], 5'd0, 0));
        expQ.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 5'd0, 1));
    endtask

    // Called at a negedge with the DUT idle. cutAt>=0 cancels after that trace index (abort or reset).
    task automatic runJob(input bit dec, input bit noise, input bit hold, input bit abortAtStart,
                          input int cutAt, input bit useReset);
        jobNo++;
        buildJob(dec);
        inStart   = 1'b1;
        inDecrypt = dec;
        inAbort   = abortAtStart;
        for (int k = 0; k < expQ.size(); k++) begin
            @(negedge clk);
            chk($sformatf("job%0d_dec%0d_k%0d", jobNo, dec, k), expQ[k]);
            inAbort   = 1'b0;
            inStart   = hold ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
            inDecrypt = noise ? 1'($urandom) : dec;
            if (k == cutAt) begin
                inStart = 1'b0;
                if (useReset) inRstN = 1'b0;
                else inAbort = 1'b1;
                @(negedge clk);
                chk($sformatf("job%0d_cut%0d", jobNo, k), IDLE_V);
                if (useReset) begin
                    @(negedge clk);
                    chk($sformatf("job%0d_inrst", jobNo), IDLE_V);
                    inRstN = 1'b1;
                end
                inAbort = 1'b0;
                @(negedge clk);
                chk($sformatf("job%0d_postcut", jobNo), IDLE_V);
                return;
            end
        end
        @(negedge clk);
        chk($sformatf("job%0d_idle", jobNo), IDLE_V);
        inStart = hold;
    endtask

    initial begin
        inRstN = 1'b0; inStart = 1'b0; inDecrypt = 1'b0; inAbort = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_hold", IDLE_V);
        inRstN = 1'b1;
        @(negedge clk);
        chk("reset_release", IDLE_V);

        runJob(0, 0, 0, 0, -1, 0);            // plain encrypt
        runJob(1, 0, 0, 0, -1, 0);            // plain decrypt
        runJob(0, 1, 1, 0, -1, 0);            // start held high, mode toggling mid-job
        runJob(0, 1, 1, 0, -1, 0);
        runJob(0, 1, 0, 0, -1, 0);
        runJob(0, 0, 0, 0, 8, 0);             // abort in round 7
        runJob(0, 0, 0, 0, -1, 0);            // restart at 0x80
        runJob(1, 0, 0, 0, 12, 0);            // decrypt aborted mid-round
        runJob(0, 0, 0, 0, 11, 1);            // reset during round 10
        runJob(1, 0, 0, 0, -1, 0);

        inAbort = 1'b1;                        // abort in IDLE does nothing
        @(negedge clk);
        chk("abort_idle", IDLE_V);
        runJob(1, 0, 0, 1, -1, 0);            // abort together with start: start wins

        for (int i = 0; i < 12; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            runJob(1'($urandom), 1, 0, 0,
                   (sel < 2) ? $urandom_range(0, 18) : -1, sel == 0);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("rand_gap", IDLE_V);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
